// File: rtl/am_demod_decim.sv
// AM envelope detector: LO mix, rescale/saturate, squared or magnitude detector,
// then integrate-and-dump decimation with a saturating accumulator.
module am_demod_decim #(
    parameter int DATA_W  = 8,
    parameter int LO_W    = 16,
    parameter int ACC_W   = 40,
    parameter int DECIM_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  adc_data,
    input  logic signed [LO_W-1:0]    lo_sin,
    input  logic signed [LO_W-1:0]    lo_cos,
    input  logic                      mode,
    input  logic        [DECIM_W-1:0] decim,
    output logic        [ACC_W-1:0]   out_data,
    output logic                      out_valid,
    output logic                      overflow
);

    localparam int PW = DATA_W + LO_W;
    localparam int DW = 2 * DATA_W;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DATA_W - 1)));

    // Floor-scale a mixer product back to DATA_W and clamp to the signed range.
    function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> (LO_W - 1);
        if (s > SAT_MAX) return DATA_W'(SAT_MAX);
        if (s < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(s);
    endfunction

    logic signed [PW-1:0]     adc_x, cos_x, sin_x;
    logic signed [PW-1:0]     ip_d, qp_d, ip_q, qp_q;
    logic signed [DATA_W-1:0] i_d, q_d, i_q, q_q;
    logic signed [DW-1:0]     ii, qq;
    logic signed [DATA_W:0]   ie, qe;
    logic        [DATA_W:0]   ai, aq;
    logic        [DW-1:0]     det_d, det_q;
    logic                     v1_q, v2_q, v3_q;

    logic [ACC_W:0]       sum_d;
    logic [ACC_W-1:0]     acc_sat, acc_q, out_data_q;
    logic [DECIM_W-1:0]   cnt_q, cnt_inc, reff_q, reff_d;
    logic                 dump, out_valid_q, overflow_q;

    always_comb begin
        adc_x = PW'(adc_data);
        cos_x = PW'(lo_cos);
        sin_x = PW'(lo_sin);
        ip_d  = adc_x * cos_x;
        qp_d  = adc_x * sin_x;
        i_d   = scale_sat(ip_q);
        q_d   = scale_sat(qp_q);
        ii    = DW'(i_q) * DW'(i_q);
        qq    = DW'(q_q) * DW'(q_q);
        ie    = (DATA_W + 1)'(i_q);
        qe    = (DATA_W + 1)'(q_q);
        ai    = ie[DATA_W] ? -ie : ie;
        aq    = qe[DATA_W] ? -qe : qe;
        det_d = mode ? (DW'(ai) + DW'(aq)) : ($unsigned(ii) + $unsigned(qq));
    end

    // Data registers only load when their stage is fed, so idle cycles keep them stable.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            ip_q <= ip_d;
            qp_q <= qp_d;
        end
        if (v1_q) begin
            i_q <= i_d;
            q_q <= q_d;
        end
        if (v2_q) det_q <= det_d;
    end

    always_comb begin
        sum_d   = {1'b0, acc_q} + (ACC_W + 1)'(det_q);
        acc_sat = sum_d[ACC_W] ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
        cnt_inc = cnt_q + DECIM_W'(1);
        dump    = v3_q && (cnt_inc == reff_q);
        reff_d  = (decim == '0) ? DECIM_W'(1) : decim;
    end

    // Reff is held in reff_q for the whole frame; a new decim is only picked up at a dump.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            reff_q      <= reff_d;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= dump;
            if (v3_q) begin
                if (sum_d[ACC_W]) overflow_q <= 1'b1;
                if (dump) begin
                    out_data_q <= acc_sat;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    reff_q     <= reff_d;
                end else begin
                    acc_q <= acc_sat;
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_am_demod_decim.sv
// Bench for am_demod_decim: default-width and 16-bit-accumulator instances driven
// in parallel, checked against a per-sample arithmetic model via a scoreboard.
module tb_am_demod_decim;

    localparam int HN = 16;
    localparam longint LIM0 = (64'sd1 <<< 40) - 1;
    localparam longint LIM1 = 65535;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, mode;
    logic [7:0]  adc_data;
    logic [15:0] lo_sin, lo_cos, decim;
    logic [39:0] out_data;
    logic        out_valid, overflow;
    logic [15:0] out_data16;
    logic        out_valid16, overflow16;

    always #5 clk = ~clk;

    am_demod_decim dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .adc_data(adc_data),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .mode(mode), .decim(decim),
        .out_data(out_data), .out_valid(out_valid), .overflow(overflow)
    );

    am_demod_decim #(.ACC_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .adc_data(adc_data),
        .lo_sin(lo_sin), .lo_cos(lo_cos), .mode(mode), .decim(decim),
        .out_data(out_data16), .out_valid(out_valid16), .overflow(overflow16)
    );

    typedef struct {
        int     cyc;
        longint data;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    longint cap[$];
    int     checks = 0;
    int     errors = 0;
    int     edge_n = 0;

    int     h_adc[HN], h_sin[HN], h_cos[HN];
    bit     h_v[HN], h_mode[HN], h_rst[HN];
    longint m_acc[2], m_hold[2];
    bit     m_ovf[2];
    int     m_cnt, m_reff;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Mixer output: floor(adc*lo / 2^15) clamped to [-128, 127].
    function automatic int iq_of(input int adc, input int lo);
        int p, v;
        p = adc * lo;
        if (p >= 0) v = p / 32768;
        else v = -((-p + 32767) / 32768);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic longint det_of(input int adc, input int s, input int c, input bit m);
        int i, q;
        i = iq_of(adc, c);
        q = iq_of(adc, s);
        if (m) return longint'((i < 0 ? -i : i) + (q < 0 ? -q : q));
        return longint'(i * i + q * q);
    endfunction

    // Reference model: a sample presented at edge k is mixed with the mode seen at
    // edge k+2 and accumulated at edge k+3, where a frame end also picks up decim.
    initial begin
        int s, k, a, b;
        longint d, sum;
        exp_t e;
        for (int i = 0; i < HN; i++) begin
            h_rst[i] = 1'b1;
            h_v[i]   = 1'b0;
        end
        m_cnt  = 0;
        m_reff = 1;
        for (int w = 0; w < 2; w++) begin
            m_acc[w]  = 0;
            m_hold[w] = 0;
            m_ovf[w]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            s = edge_n % HN;
            h_v[s]    = in_valid;
            h_adc[s]  = int'($signed(adc_data));
            h_sin[s]  = int'($signed(lo_sin));
            h_cos[s]  = int'($signed(lo_cos));
            h_mode[s] = mode;
            h_rst[s]  = !reset_n;
            if (!reset_n) begin
                m_cnt  = 0;
                m_reff = eff(int'(decim));
                for (int w = 0; w < 2; w++) begin
                    m_acc[w]  = 0;
                    m_hold[w] = 0;
                    m_ovf[w]  = 1'b0;
                end
            end else if (edge_n >= 3) begin
                k = (edge_n - 3) % HN;
                a = (edge_n - 2) % HN;
                b = (edge_n - 1) % HN;
                if (h_v[k] && !h_rst[k] && !h_rst[a] && !h_rst[b]) begin
                    d = det_of(h_adc[k], h_sin[k], h_cos[k], h_mode[b]);
                    m_cnt++;
                    for (int w = 0; w < 2; w++) begin
                        sum = m_acc[w] + d;
                        if (sum > ((w == 0) ? LIM0 : LIM1)) begin
                            sum      = (w == 0) ? LIM0 : LIM1;
                            m_ovf[w] = 1'b1;
                        end
                        if (m_cnt == m_reff) begin
                            m_hold[w] = sum;
                            m_acc[w]  = 0;
                            e.cyc     = edge_n;
                            e.data    = sum;
                            if (w == 0) q0.push_back(e);
                            else q1.push_back(e);
                        end else begin
                            m_acc[w] = sum;
                        end
                    end
                    if (m_cnt == m_reff) begin
                        m_cnt  = 0;
                        m_reff = eff(int'(decim));
                    end
                end
            end
            edge_n++;
        end
    end

    task automatic mon(input int w, input logic v, input longint data, input logic ov);
        bit   ev;
        exp_t e;
        string tag;
        tag = (w == 0) ? "acc40" : "acc16";
        if (w == 0) ev = (q0.size() > 0) && (q0[0].cyc == edge_n - 1);
        else ev = (q1.size() > 0) && (q1[0].cyc == edge_n - 1);
        chk({tag, " out_valid"}, longint'(v), longint'(ev));
        if (ev) begin
            if (w == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk({tag, " dump_data"}, data, e.data);
        end
        chk({tag, " out_data_hold"}, data, m_hold[w]);
        chk({tag, " overflow"}, longint'(ov), longint'(m_ovf[w]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                mon(0, out_valid, longint'(out_data), overflow);
                mon(1, out_valid16, longint'(out_data16), overflow16);
                if (out_valid) cap.push_back(longint'(out_data));
            end
        end
    end

    task automatic wait_out(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        mode     = 1'b0;
        decim    = 16'd4;
        adc_data = 8'd64;
        lo_cos   = 16'd32767;
        lo_sin   = 16'd0;

        // Reset held with samples offered; outputs must stay cleared.
        repeat (3) begin
            @(negedge clk);
            chk("reset out_data", longint'(out_data), 0);
            chk("reset out_valid", longint'(out_valid), 0);
            chk("reset overflow", longint'(overflow), 0);
        end
        reset_n = 1'b1;

        // Squared detector, R = 4.
        wait_out(n);
        chk("sq first latency", n, 7);
        chk("sq first data", longint'(out_data), 15876);
        wait_out(n);
        chk("sq period", n, 4);
        chk("sq second data", longint'(out_data), 15876);

        // Magnitude detector, decim = 0 acts as R = 1.
        mode   = 1'b1;
        decim  = 16'd0;
        lo_sin = 16'h8000;
        do_reset();
        wait_out(n);
        chk("mag latency", n, 4);
        chk("mag data", longint'(out_data), 127);
        wait_out(n);
        chk("mag continuous", n, 1);
        wait_out(n);
        chk("mag continuous 2", n, 1);

        // I saturates from +128 to +127.
        mode     = 1'b0;
        decim    = 16'd1;
        adc_data = 8'h80;
        lo_cos   = 16'h8000;
        lo_sin   = 16'd0;
        do_reset();
        wait_out(n);
        chk("sat latency", n, 4);
        chk("sat data", longint'(out_data), 16129);
        chk("sat data acc16", longint'(out_data16), 16129);

        // 16-bit accumulator overflow.
        decim  = 16'd3;
        lo_cos = 16'h7FFF;
        lo_sin = 16'h7FFF;
        do_reset();
        wait_out(n);
        chk("ovf latency", n, 6);
        chk("ovf data acc16", longint'(out_data16), 65535);
        chk("ovf flag acc16", longint'(overflow16), 1);
        chk("ovf data acc40", longint'(out_data), 98304);
        chk("ovf flag acc40", longint'(overflow), 0);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("ovf sticky acc16", longint'(overflow16), 1);

        // Gapped input with R = 2, then a mid-frame decim change.
        decim    = 16'd2;
        adc_data = 8'd64;
        lo_cos   = 16'd32767;
        lo_sin   = 16'd0;
        do_reset();
        cap.delete();
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("gap dump count", cap.size(), 3);
        for (int i = 0; i < cap.size(); i++) chk("gap dump data", cap[i], 7938);

        cap.delete();
        in_valid = 1'b1;
        @(negedge clk);
        decim = 16'd3;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("decim change count", cap.size(), 2);
        if (cap.size() == 2) begin
            chk("decim change frame1", cap[0], 7938);
            chk("decim change frame2", cap[1], 11907);
        end

        // Randomized traffic with mode/decim changes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom % 4) != 0;
            adc_data = ($urandom % 8 == 0) ? 8'h80 : 8'($urandom);
            lo_cos   = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            lo_sin   = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            if ($urandom % 30 == 0) mode = 1'($urandom);
            if ($urandom % 40 == 0) decim = 16'($urandom_range(0, 5));
            reset_n = ($urandom % 400) != 0;
            @(negedge clk);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("scoreboard drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
